vecmac_dot_acc: RTL and testbench

Parametrised successor to the fixed 16-lane 8x8 Wallace dot-product unit. Computes a LANES-wide DW-bit dot product per beat with selectable signed or unsigned operands. Accumulates consecutive beats into one packet result, delimited by in_last. Uses a valid/ready handshake on both sides, with full-pipeline stall on output backpressure. Sits between the operand streamer and the result writeback.

---
 rtl/vecmac_dot_acc.sv | 344 ++++++++++++++++++++++++++++++++++
 tb/tb_vecmac_dot_acc.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vecmac_dot_acc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vecmac_dot_acc                                                  |
// | Purpose  : LANES-wide DW-bit dot product per beat with per-packet signed / |
// |            unsigned mode. Consecutive beats are accumulated into one       |
// |            packet result that is delimited by in_last.                     |
// |            Valid/ready on both sides. Output backpressure stalls the whole |
// |            pipeline.                                                       |
// | Ports    : clk, rst           - clock, synchronous active-high reset       |
// |            in_valid/in_ready  - input beat handshake                       |
// |            in_a, in_b         - packed operands, lane i at [i*DW +: DW]    |
// |            in_signed          - packet mode, taken from the first beat     |
// |            in_last            - final beat of the packet                   |
// |            out_valid/out_ready- result handshake                           |
// |            out_sum            - accumulated packet sum                     |
// |            out_ovf            - sticky accumulator overflow of the packet  |
// |            out_beats          - saturating beat count of the packet        |
// | Revision : 1.0 - initial parametrised release                              |
// +----------------------------------------------------------------------------+
module vecmac_dot_acc #(
  parameter int LANES = 16,
  parameter int DW    = 8,
  parameter int PIPE  = 2,
  parameter int ACC_W = 32,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*DW-1:0]   in_a,
  input  logic [LANES*DW-1:0]   in_b,
  input  logic                  in_signed,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_W-1:0]      out_sum,
  output logic                  out_ovf,
  output logic [CNT_W-1:0]      out_beats
);

  // Per-beat dot width: a full-width product plus one bit per tree level.
  localparam int DOT_W = 2*DW + $clog2(LANES);

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  // Extends one lane operand to DOT_W. Because both operands are extended to
  // the result width, the low DOT_W bits of a plain multiply are the exact
  // signed or unsigned product.
  function automatic logic [DOT_W-1:0] lane_ext(input logic [DW-1:0] x,
                                                input logic          sgn);
    return {{(DOT_W-DW){sgn & x[DW-1]}}, x};
  endfunction

  // Balanced pairwise adder tree. In-place reduction is safe because at each
  // level entry i only reads entries 2i and 2i+1, which are never below i.
  function automatic logic [DOT_W-1:0] tree_sum(input logic [DOT_W-1:0] p [LANES]);
    logic [DOT_W-1:0] t [LANES];
    t = p;
    for (int w = LANES / 2; w >= 1; w = w / 2) begin
      for (int i = 0; i < w; i++) begin
        t[i] = t[2*i] + t[2*i+1];
      end
    end
    return t[0];
  endfunction

  // --------------------------------------------------------------------------
  // Global enable: the only stall source is a held, unconsumed result.
  // --------------------------------------------------------------------------
  logic en;
  logic in_fire;
  logic out_valid_q;

  assign en       = !(out_valid_q && !out_ready);
  assign in_ready = en;
  assign in_fire  = in_valid && en;

  // --------------------------------------------------------------------------
  // Packet mode capture on the input side. The mode of the first beat is
  // remembered and reused for every later beat of the same packet.
  // --------------------------------------------------------------------------
  logic in_first_q, in_first_d;
  logic pkt_mode_q, pkt_mode_d;
  logic beat_mode;

  always_comb begin
    beat_mode  = in_first_q ? in_signed : pkt_mode_q;
    in_first_d = in_first_q;
    pkt_mode_d = pkt_mode_q;
    if (in_fire) begin
      in_first_d = in_last;
      pkt_mode_d = beat_mode;
    end
  end

  // --------------------------------------------------------------------------
  // Input register stage
  // --------------------------------------------------------------------------
  logic                s0_valid_q, s0_valid_d;
  logic                s0_last_q,  s0_last_d;
  logic                s0_mode_q,  s0_mode_d;
  logic [LANES*DW-1:0] s0_a_q,     s0_a_d;
  logic [LANES*DW-1:0] s0_b_q,     s0_b_d;

  always_comb begin
    s0_valid_d = s0_valid_q;
    s0_last_d  = s0_last_q;
    s0_mode_d  = s0_mode_q;
    s0_a_d     = s0_a_q;
    s0_b_d     = s0_b_q;
    if (en) begin
      s0_valid_d = in_fire;
      if (in_fire) begin
        s0_last_d = in_last;
        s0_mode_d = beat_mode;
        s0_a_d    = in_a;
        s0_b_d    = in_b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid_q <= 1'b0;
      in_first_q <= 1'b1;
      pkt_mode_q <= 1'b0;
    end else begin
      s0_valid_q <= s0_valid_d;
      in_first_q <= in_first_d;
      pkt_mode_q <= pkt_mode_d;
    end
    s0_last_q <= s0_last_d;
    s0_mode_q <= s0_mode_d;
    s0_a_q    <= s0_a_d;
    s0_b_q    <= s0_b_d;
  end

  // --------------------------------------------------------------------------
  // Lane products (combinational from the input register)
  // --------------------------------------------------------------------------
  logic [DOT_W-1:0] prod_w [LANES];

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      prod_w[i] = lane_ext(s0_a_q[i*DW +: DW], s0_mode_q) *
                  lane_ext(s0_b_q[i*DW +: DW], s0_mode_q);
    end
  end

  // --------------------------------------------------------------------------
  // Multiply / reduction tree: PIPE register stages. With one stage the whole
  // tree sits in front of it; otherwise the products are registered first,
  // the tree is reduced into stage 2 and any further stages are retiming
  // slack for the tree.
  // --------------------------------------------------------------------------
  logic             t_valid;
  logic             t_last;
  logic             t_mode;
  logic [DOT_W-1:0] t_dot;

  generate
    if (PIPE == 1) begin : g_pipe_one
      logic             v_q, v_d;
      logic             l_q, l_d;
      logic             m_q, m_d;
      logic [DOT_W-1:0] dot_q, dot_d;

      always_comb begin
        v_d   = v_q;
        l_d   = l_q;
        m_d   = m_q;
        dot_d = dot_q;
        if (en) begin
          v_d = s0_valid_q;
          l_d = s0_last_q;
          m_d = s0_mode_q;
          if (s0_valid_q) begin
            dot_d = tree_sum(prod_w);
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          v_q <= 1'b0;
        end else begin
          v_q <= v_d;
        end
        l_q   <= l_d;
        m_q   <= m_d;
        dot_q <= dot_d;
      end

      assign t_valid = v_q;
      assign t_last  = l_q;
      assign t_mode  = m_q;
      assign t_dot   = dot_q;
    end else begin : g_pipe_multi
      logic [PIPE-1:0]  v_q, v_d;
      logic [PIPE-1:0]  l_q, l_d;
      logic [PIPE-1:0]  m_q, m_d;
      logic [DOT_W-1:0] prod_q [LANES];
      logic [DOT_W-1:0] prod_d [LANES];
      // dot_q[0] is stage 2, dot_q[PIPE-2] is the last tree stage
      logic [DOT_W-1:0] dot_q [PIPE-1];
      logic [DOT_W-1:0] dot_d [PIPE-1];

      always_comb begin
        v_d    = v_q;
        l_d    = l_q;
        m_d    = m_q;
        prod_d = prod_q;
        dot_d  = dot_q;
        if (en) begin
          v_d = {v_q[PIPE-2:0], s0_valid_q};
          l_d = {l_q[PIPE-2:0], s0_last_q};
          m_d = {m_q[PIPE-2:0], s0_mode_q};
          if (s0_valid_q) begin
            prod_d = prod_w;
          end
          if (v_q[0]) begin
            dot_d[0] = tree_sum(prod_q);
          end
          for (int s = 1; s < PIPE-1; s++) begin
            if (v_q[s]) begin
              dot_d[s] = dot_q[s-1];
            end
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          v_q <= '0;
        end else begin
          v_q <= v_d;
        end
        l_q    <= l_d;
        m_q    <= m_d;
        prod_q <= prod_d;
        dot_q  <= dot_d;
      end

      assign t_valid = v_q[PIPE-1];
      assign t_last  = l_q[PIPE-1];
      assign t_mode  = m_q[PIPE-1];
      assign t_dot   = dot_q[PIPE-2];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Accumulate stage and result registers
  // --------------------------------------------------------------------------
  logic             acc_first_q, acc_first_d;
  logic [ACC_W-1:0] acc_q,       acc_d;
  logic             acc_ovf_q,   acc_ovf_d;
  logic [CNT_W-1:0] beats_q,     beats_d;
  logic             out_valid_d;
  logic [ACC_W-1:0] out_sum_q,   out_sum_d;
  logic             out_ovf_q,   out_ovf_d;
  logic [CNT_W-1:0] out_beats_q, out_beats_d;

  logic [ACC_W-1:0] dot_ext;
  logic [ACC_W-1:0] acc_base;
  logic [ACC_W:0]   acc_sum;
  logic             step_ovf;
  logic             ovf_new;
  logic [CNT_W-1:0] beats_new;

  always_comb begin
    // Sign- or zero-extend the beat result to the accumulator width.
    dot_ext              = {ACC_W{t_mode & t_dot[DOT_W-1]}};
    dot_ext[DOT_W-1:0]   = t_dot;
    acc_base             = acc_first_q ? '0 : acc_q;
    acc_sum              = {1'b0, acc_base} + {1'b0, dot_ext};
    if (t_mode) begin
      // Signed overflow: operands agree in sign, result does not.
      step_ovf = (acc_base[ACC_W-1] == dot_ext[ACC_W-1]) &&
                 (acc_sum[ACC_W-1] != acc_base[ACC_W-1]);
    end else begin
      step_ovf = acc_sum[ACC_W];
    end
    ovf_new   = (acc_first_q ? 1'b0 : acc_ovf_q) | step_ovf;
    beats_new = acc_first_q ? CNT_W'(1)
              : (&beats_q ? beats_q : beats_q + CNT_W'(1));

    acc_first_d = acc_first_q;
    acc_d       = acc_q;
    acc_ovf_d   = acc_ovf_q;
    beats_d     = beats_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_ovf_d   = out_ovf_q;
    out_beats_d = out_beats_q;
    if (en) begin
      // With en high any held result is consumed at this edge, so out_valid
      // only survives if a new result replaces it (no bubble).
      out_valid_d = 1'b0;
      if (t_valid) begin
        acc_d       = acc_sum[ACC_W-1:0];
        acc_ovf_d   = ovf_new;
        beats_d     = beats_new;
        acc_first_d = t_last;
        if (t_last) begin
          out_valid_d = 1'b1;
          out_sum_d   = acc_sum[ACC_W-1:0];
          out_ovf_d   = ovf_new;
          out_beats_d = beats_new;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_first_q <= 1'b1;
      acc_q       <= '0;
      acc_ovf_q   <= 1'b0;
      beats_q     <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_beats_q <= '0;
    end else begin
      acc_first_q <= acc_first_d;
      acc_q       <= acc_d;
      acc_ovf_q   <= acc_ovf_d;
      beats_q     <= beats_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_ovf_q   <= out_ovf_d;
      out_beats_q <= out_beats_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;
  assign out_beats = out_beats_q;

endmodule
`default_nettype wire

// File: tb/tb_vecmac_dot_acc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_vecmac_dot_acc                                               |
// | Purpose  : Self-checking bench for vecmac_dot_acc. A default build and an  |
// |            ACC_W=20 build share one input stream; a packet-level model     |
// |            predicts every result and a per-cycle monitor compares both.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_vecmac_dot_acc;

  localparam int LANES = 16;
  localparam int DW    = 8;
  localparam int W     = LANES*DW;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_signed;
  logic         in_last;
  logic         out_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;

  logic         in_ready,  out_valid,  out_ovf;
  logic [31:0]  out_sum;
  logic [15:0]  out_beats;
  logic         in_ready20, out_valid20, out_ovf20;
  logic [19:0]  out_sum20;
  logic [15:0]  out_beats20;

  always #5 clk = ~clk;

  vecmac_dot_acc #(.LANES(LANES), .DW(DW), .PIPE(2), .ACC_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf), .out_beats(out_beats)
  );

  vecmac_dot_acc #(.LANES(LANES), .DW(DW), .PIPE(2), .ACC_W(20), .CNT_W(16)) dut20 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready20),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_last(in_last),
    .out_valid(out_valid20), .out_ready(out_ready),
    .out_sum(out_sum20), .out_ovf(out_ovf20), .out_beats(out_beats20)
  );

  int checks = 0;
  int errors = 0;

  function automatic void check(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic void fail_now(string nm, longint act);
    checks++;
    errors++;
    $display("FAIL %s: got %0d expected none (t=%0t)", nm, act, $time);
  endfunction

  // --------------------------------------------------------------------------
  // Packet-level reference model
  // --------------------------------------------------------------------------
  typedef struct {
    logic [31:0] sum;
    logic        ovf;
    logic [19:0] sum20;
    logic        ovf20;
    int          beats;
  } res_t;

  res_t   exp_q[$];
  bit     m_first = 1'b1;
  bit     m_mode;
  longint m_acc32, m_acc20;
  bit     m_ovf32, m_ovf20;
  int     m_beats;

  function automatic longint dot_of(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn);
    longint   s = 0;
    logic [7:0] x, y;
    for (int i = 0; i < LANES; i++) begin
      x = a[i*DW +: DW];
      y = b[i*DW +: DW];
      if (sgn) s += longint'($signed(x)) * longint'($signed(y));
      else     s += longint'(x) * longint'(y);
    end
    return s;
  endfunction

  // One accumulation step on a wrap-around register of width w.
  function automatic void acc_step(input bit sgn, input int w, input longint dot,
                                   inout longint acc, inout bit ovf);
    longint m = longint'(1) << w;
    longint v = acc;
    if (sgn && acc >= m/2) v = acc - m;
    v = v + dot;
    if (sgn) begin
      if (v >= m/2 || v < -(m/2)) ovf = 1'b1;
    end else if (v >= m) begin
      ovf = 1'b1;
    end
    acc = v & (m - 1);
  endfunction

  // --------------------------------------------------------------------------
  // Monitor: checks outputs every cycle, then advances the model for the edge
  // that follows. Inputs only change just after a rising edge.
  // --------------------------------------------------------------------------
  bit armed = 1'b0;
  int stall_cycles = 0;

  always @(negedge clk) begin
    if (armed) begin
      if (out_valid && !out_ready) stall_cycles++;
      check("in_ready", in_ready, !(out_valid && !out_ready));
      check("in_ready20", in_ready20, !(out_valid20 && !out_ready));
      if (out_valid) begin
        if (exp_q.size() == 0) fail_now("unexpected_result", out_sum);
        else begin
          check("sum", out_sum, exp_q[0].sum);
          check("ovf", out_ovf, exp_q[0].ovf);
          check("beats", out_beats, exp_q[0].beats);
        end
      end
      if (out_valid20) begin
        if (exp_q.size() == 0) fail_now("unexpected_result20", out_sum20);
        else begin
          check("sum20", out_sum20, exp_q[0].sum20);
          check("ovf20", out_ovf20, exp_q[0].ovf20);
          check("beats20", out_beats20, exp_q[0].beats);
        end
      end
      if (rst) begin
        exp_q.delete();
        m_first = 1'b1;
      end else begin
        if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
        if (in_valid && in_ready) begin
          longint d;
          if (m_first) begin
            m_mode  = in_signed;
            m_acc32 = 0; m_acc20 = 0;
            m_ovf32 = 0; m_ovf20 = 0;
            m_beats = 0;
          end
          d = dot_of(in_a, in_b, m_mode);
          acc_step(m_mode, 32, d, m_acc32, m_ovf32);
          acc_step(m_mode, 20, d, m_acc20, m_ovf20);
          m_beats = (m_beats < 65535) ? m_beats + 1 : 65535;
          if (in_last) begin
            res_t r;
            r.sum = m_acc32[31:0]; r.ovf = m_ovf32;
            r.sum20 = m_acc20[19:0]; r.ovf20 = m_ovf20;
            r.beats = m_beats;
            exp_q.push_back(r);
          end
          m_first = in_last;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Downstream ready driver: 0 = always ready, 1 = random, 2 = held low
  // --------------------------------------------------------------------------
  int rdy_mode = 0;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        2:       out_ready = 1'b0;
        default: out_ready = ($urandom_range(0, 99) < 70);
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  function automatic logic [W-1:0] fill(input logic [7:0] v);
    return {LANES{v}};
  endfunction

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return fill(8'hFF);
      1:       return fill(8'h80);
      2:       return fill(8'h7F);
      default: return {$urandom(), $urandom(), $urandom(), $urandom()};
    endcase
  endfunction

  // Presents one beat and returns just after the edge that accepts it.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input bit sgn, input bit last);
    int budget = 0;
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_signed = sgn;
    in_last   = last;
    @(negedge clk);
    while (!in_ready) begin
      budget++;
      if (budget > 2000) begin
        fail_now("accept_timeout", budget);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_a      = rnd_op();
    in_b      = rnd_op();
    in_signed = $urandom_range(0, 1);
    in_last   = $urandom_range(0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    int          lat;
    logic [31:0] sum;
    logic        ovf;
    logic [15:0] beats;
    logic [19:0] sum20;
    logic        ovf20;
  } obs_t;

  // Waits for the next result; lat counts cycles after the accepting edge.
  task automatic wait_result(output obs_t o);
    o.lat = -1; o.sum = '0; o.ovf = 1'b0; o.beats = '0; o.sum20 = '0; o.ovf20 = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (out_valid) begin
        o.lat = k; o.sum = out_sum; o.ovf = out_ovf; o.beats = out_beats;
        o.sum20 = out_sum20; o.ovf20 = out_ovf20;
        break;
      end
    end
    if (o.lat < 0) fail_now("result_timeout", o.lat);
    @(posedge clk);
    #1;
  endtask

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    obs_t o;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst   = 1'b0;
    armed = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_ovf", out_ovf, 0);
    check("rst_out_beats", out_beats, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // 1: unsigned single beat FF x FF, latency 3
    send(fill(8'hFF), fill(8'hFF), 1'b0, 1'b1);
    wait_result(o);
    check("t1_latency", o.lat, 3);
    check("t1_sum", o.sum, 1040400);
    check("t1_ovf", o.ovf, 0);
    check("t1_beats", o.beats, 1);

    // 2: signed extremes
    send(fill(8'h80), fill(8'h80), 1'b1, 1'b1);
    wait_result(o);
    check("t2a_sum", o.sum, 262144);
    check("t2a_ovf", o.ovf, 0);
    send(fill(8'h80), fill(8'h7F), 1'b1, 1'b1);
    wait_result(o);
    check("t2b_sum", o.sum, 32'hFFFC0800);
    check("t2b_ovf", o.ovf, 0);

    // 3: four-beat packet with gaps, in_signed toggled on later beats
    for (int n = 0; n < 4; n++) begin
      send(fill(8'h01), fill(8'h02), (n == 0) ? 1'b0 : 1'b1, n == 3);
      if (n < 3) begin
        @(negedge clk);
        check("t3_no_early", out_valid, 0);
        @(posedge clk); #1;
      end
    end
    wait_result(o);
    check("t3_sum", o.sum, 128);
    check("t3_beats", o.beats, 4);
    check("t3_latency", o.lat, 3);

    // 5: ACC_W=20 build carry-out
    send(fill(8'hFF), fill(8'hFF), 1'b0, 1'b0);
    send(fill(8'hFF), fill(8'hFF), 1'b0, 1'b1);
    wait_result(o);
    check("t5_sum32", o.sum, 2080800);
    check("t5_ovf32", o.ovf, 0);
    check("t5_sum20", o.sum20, 1032224);
    check("t5_ovf20", o.ovf20, 1);

    // 6: reset mid-packet
    send(fill(8'h11), fill(8'h22), 1'b0, 1'b0);
    send(fill(8'h33), fill(8'h44), 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_sum", out_sum, 0);
    check("t6_rst_beats", out_beats, 0);
    check("t6_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    send(fill(8'h01), fill(8'h01), 1'b0, 1'b1);
    wait_result(o);
    check("t6_sum", o.sum, 16);
    check("t6_beats", o.beats, 1);
    check("t6_ovf", o.ovf, 0);

    // 4: 20 single-beat packets with a 10-cycle downstream stall
    stall_cycles = 0;
    fork
      begin
        for (int n = 0; n < 20; n++) send(rnd_op(), rnd_op(), $urandom_range(0, 1), 1'b1);
      end
      begin
        repeat (8) @(posedge clk);
        rdy_mode = 2;
        repeat (10) @(posedge clk);
        rdy_mode = 0;
      end
    join
    idle(8);
    check("t4_stall_cycles", stall_cycles, 10);
    check("t4_drained", exp_q.size(), 0);

    // Random traffic
    rdy_mode = 1;
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 99) < 30) idle($urandom_range(1, 3));
      send(rnd_op(), rnd_op(), $urandom_range(0, 1),
           (n == 9999) ? 1'b1 : ($urandom_range(0, 3) == 0));
    end

    // Drain
    rdy_mode = 0;
    for (int k = 0; k < 100 && (exp_q.size() != 0 || out_valid); k++) idle(1);
    check("final_drained", exp_q.size(), 0);
    check("final_out_valid", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
